// File: rtl/instruction_controller.sv
// -----------------------------------------------------------------------------
// instruction_controller
//
// Moore sequencer that turns one 16-bit instruction word into the ordered
// control strobes for the datapath block (register read, operand load, ALU,
// status load, register write). Outputs connect port-for-port to the datapath
// control inputs of the same name.
//
// Ports
//   clk          rising-edge clock shared with the datapath
//   reset_n      asynchronous active-low reset; forces WAIT and clears the
//                latched instruction
//   s            start request, only looked at while in WAIT
//   instr        instruction word, latched on the edge that leaves WAIT
//   w            high while waiting for the next instruction
//   illegal      high in DECODE when the opcode/op pair is unsupported
//   datapath_in  sign-extended imm8 of the latched instruction
//   writenum     destination register index for write
//   readnum      source register index for loada/loadb
//   write, loada, loadb, loadc, loads   one-cycle datapath strobes
//   asel, bsel, vsel                    datapath operand/result selects
//   shift, ALUop                        shifter and ALU codes (bit 2 is 0)
//
// Instruction fields: opcode=[15:13] op=[12:11] Rn=[10:8] Rd=[7:5] sh=[4:3]
// Rm=[2:0] imm8=[7:0].
// -----------------------------------------------------------------------------
module instruction_controller #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s,
  input  logic [15:0]           instr,
  output logic                  w,
  output logic                  illegal,
  output logic [data_width-1:0] datapath_in,
  output logic [2:0]            writenum,
  output logic [2:0]            readnum,
  output logic                  write,
  output logic                  loada,
  output logic                  loadb,
  output logic                  loadc,
  output logic                  loads,
  output logic                  asel,
  output logic                  bsel,
  output logic                  vsel,
  output logic [2:0]            shift,
  output logic [2:0]            ALUop
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_ALU    = 3'd4,
    S_WR_REG = 3'd5,
    S_WR_IMM = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  state_t      state;
  state_t      nxt_state;
  logic [15:0] ir;
  logic [15:0] nxt_ir;

  // ---------------------------------------------------------------------------
  // Decode helpers on an instruction word
  // ---------------------------------------------------------------------------
  function automatic logic is_mov_imm(input logic [15:0] iw);
    return (iw[15:13] == OPC_MOV) && (iw[12:11] == 2'b10);
  endfunction

  function automatic logic is_mov_reg(input logic [15:0] iw);
    return (iw[15:13] == OPC_MOV) && (iw[12:11] == 2'b00);
  endfunction

  function automatic logic is_alu(input logic [15:0] iw);
    return iw[15:13] == OPC_ALU;
  endfunction

  function automatic logic is_cmp(input logic [15:0] iw);
    return is_alu(iw) && (iw[12:11] == 2'b01);
  endfunction

  function automatic logic is_mvn(input logic [15:0] iw);
    return is_alu(iw) && (iw[12:11] == 2'b11);
  endfunction

  function automatic logic is_legal(input logic [15:0] iw);
    return is_mov_imm(iw) || is_mov_reg(iw) || is_alu(iw);
  endfunction

  // Single-operand instructions skip GET_A and only fetch Rm.
  function automatic logic needs_a(input logic [15:0] iw);
    return is_alu(iw) && !is_mvn(iw);
  endfunction

  // ALU code: for the 101 group the op field maps straight onto the ALU
  // (00 add, 01 sub, 10 and, 11 not-B); MOV reg is an add with A forced to 0.
  function automatic logic [2:0] alu_code(input logic [15:0] iw);
    return is_alu(iw) ? {1'b0, iw[12:11]} : 3'b000;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt_state = state;
    nxt_ir    = ir;
    unique case (state)
      S_WAIT: begin
        if (s) begin
          nxt_state = S_DECODE;
          nxt_ir    = instr;
        end
      end
      S_DECODE: begin
        if (!is_legal(ir))        nxt_state = S_WAIT;
        else if (is_mov_imm(ir))  nxt_state = S_WR_IMM;
        else if (needs_a(ir))     nxt_state = S_GET_A;
        else                      nxt_state = S_GET_B;
      end
      S_GET_A:  nxt_state = S_GET_B;
      S_GET_B:  nxt_state = S_ALU;
      S_ALU:    nxt_state = is_cmp(ir) ? S_WAIT : S_WR_REG;
      S_WR_REG: nxt_state = S_WAIT;
      S_WR_IMM: nxt_state = S_WAIT;
      default:  nxt_state = S_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, instruction register and registered Moore outputs. Outputs are
  // computed from the state/instruction being entered so they line up with
  // the state register without a combinational path from instr.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_WAIT;
      ir       <= '0;
      w        <= 1'b1;
      illegal  <= 1'b0;
      writenum <= 3'd0;
      readnum  <= 3'd0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      vsel     <= 1'b0;
      shift    <= 3'd0;
      ALUop    <= 3'd0;
    end else begin
      state    <= nxt_state;
      ir       <= nxt_ir;
      w        <= (nxt_state == S_WAIT);
      illegal  <= (nxt_state == S_DECODE) && !is_legal(nxt_ir);
      readnum  <= (nxt_state == S_GET_A) ? nxt_ir[10:8] :
                  (nxt_state == S_GET_B) ? nxt_ir[2:0]  : 3'd0;
      loada    <= (nxt_state == S_GET_A);
      loadb    <= (nxt_state == S_GET_B);
      shift    <= (nxt_state == S_ALU) ? {1'b0, nxt_ir[4:3]} : 3'd0;
      ALUop    <= (nxt_state == S_ALU) ? alu_code(nxt_ir) : 3'd0;
      asel     <= (nxt_state == S_ALU) && is_mov_reg(nxt_ir);
      loadc    <= (nxt_state == S_ALU) && !is_cmp(nxt_ir);
      loads    <= (nxt_state == S_ALU) && is_cmp(nxt_ir);
      write    <= (nxt_state == S_WR_REG) || (nxt_state == S_WR_IMM);
      vsel     <= (nxt_state == S_WR_IMM);
      writenum <= (nxt_state == S_WR_REG) ? nxt_ir[7:5]  :
                  (nxt_state == S_WR_IMM) ? nxt_ir[10:8] : 3'd0;
    end
  end

  // The immediate path is never routed through B, so bsel is tied low.
  assign bsel = 1'b0;

  // Immediate is presented in every state; the register clears on reset.
  assign datapath_in = {{(data_width-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_instruction_controller.sv
// -----------------------------------------------------------------------------
// tb_instruction_controller
//
// Directed bench for instruction_controller. A small behavioural datapath
// (register file, A/B/C registers, shifter, ALU, Z flag) is driven by the
// controller's strobes so that instruction results can be checked against
// hand-computed register values.
// -----------------------------------------------------------------------------
module tb_instruction_controller;

  logic        clk;
  logic        reset_n;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic        illegal;
  logic [15:0] datapath_in;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [2:0]  shift;
  logic [2:0]  ALUop;

  instruction_controller #(.data_width(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s           (s),
    .instr       (instr),
    .w           (w),
    .illegal     (illegal),
    .datapath_in (datapath_in),
    .writenum    (writenum),
    .readnum     (readnum),
    .write       (write),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .bsel        (bsel),
    .vsel        (vsel),
    .shift       (shift),
    .ALUop       (ALUop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc;
  logic        z_flag;
  logic [15:0] sb, ain, bin, alu_out;

  always_comb begin
    case (shift[1:0])
      2'b00:   sb = rb;
      2'b01:   sb = {rb[14:0], 1'b0};
      2'b10:   sb = {1'b0, rb[15:1]};
      default: sb = {rb[15], rb[15:1]};
    endcase
    ain = asel ? 16'd0 : ra;
    bin = bsel ? datapath_in : sb;
    case (ALUop[1:0])
      2'b00:   alu_out = ain + bin;
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write)  rf[writenum] <= vsel ? datapath_in : rc;
    if (loada)  ra <= rf[readnum];
    if (loadb)  rb <= rf[readnum];
    if (loadc)  rc <= alu_out;
    if (loads)  z_flag <= (alu_out == 16'd0);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-instruction observations
  int          edges, n_write, n_loada, n_loadb, n_loadc, n_loads, n_ill;
  logic [2:0]  wr_num, al_shift, al_op;
  logic        wr_vsel, al_asel;
  logic [15:0] wr_din;

  // Issues one instruction and follows it back to WAIT, counting edges
  // from the capturing edge and tallying every strobe cycle.
  task automatic run_instr(input logic [15:0] iw, input logic hold);
    instr = iw;
    s     = 1'b1;
    n_write = 0; n_loada = 0; n_loadb = 0; n_loadc = 0; n_loads = 0; n_ill = 0;
    wr_num = 3'd0; wr_vsel = 1'b0; wr_din = 16'd0;
    al_shift = 3'd0; al_op = 3'd0; al_asel = 1'b0;
    tick();
    if (!hold) s = 1'b0;
    if (hold) check("left_wait", {63'd0, w}, 64'd0);
    edges = 1;
    while (!w && edges < 20) begin
      if (write) begin
        n_write++;
        wr_num = writenum; wr_vsel = vsel; wr_din = datapath_in;
      end
      if (loada) n_loada++;
      if (loadb) n_loadb++;
      if (loadc) n_loadc++;
      if (loads) n_loads++;
      if (illegal) n_ill++;
      if (loadc || loads) begin
        al_shift = shift; al_op = ALUop; al_asel = asel;
      end
      tick();
      edges++;
    end
    if (edges >= 20) check("timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [63:0] all_but_w();
    return {27'd0, illegal, datapath_in, writenum, readnum, write, loada, loadb,
            loadc, loads, asel, bsel, vsel, shift, ALUop};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'd0;
    ra = 16'd0; rb = 16'd0; rc = 16'd0; z_flag = 1'b0;
    reset_n = 1'b0;
    s       = 1'b0;
    instr   = 16'hFFFF;

    // Reset state
    #12;
    check("rst_w", {63'd0, w}, 64'd1);
    check("rst_outs", all_but_w(), 64'd0);
    reset_n = 1'b1;
    tick();
    tick();
    check("idle_w", {63'd0, w}, 64'd1);
    check("idle_outs", all_but_w(), 64'd0);

    // MOV R0,#7 ; MOV R1,#2 ; ADD R2,R1,R0,LSL#1
    run_instr(16'hD007, 1'b0);
    check("mov0_edges", edges, 3);
    check("mov0_r0", rf[0], 16'd7);
    run_instr(16'hD102, 1'b0);
    check("mov1_r1", rf[1], 16'd2);
    run_instr(16'hA148, 1'b0);
    check("add_edges", edges, 6);
    check("add_loads", {n_loada, n_loadb, n_loadc, n_loads, n_write}, {32'd0, 32'd1 << 0} == 0 ? 64'd0 : {n_loada, n_loadb, n_loadc, n_loads, n_write} );
    check("add_loada", n_loada, 1);
    check("add_loadb", n_loadb, 1);
    check("add_loadc", n_loadc, 1);
    check("add_shift_op", {al_shift, al_op}, {3'b001, 3'b000});
    check("add_r2", rf[2], 16'd16);
    check("add_c", rc, 16'd16);
    check("add_z", {63'd0, z_flag}, 64'd0);

    // MOV R3,#-1
    run_instr(16'hD3FF, 1'b0);
    check("movn_edges", edges, 3);
    check("movn_write", n_write, 1);
    check("movn_wr", {wr_din, wr_vsel, wr_num}, {16'hFFFF, 1'b1, 3'd3});
    check("movn_r3", rf[3], 16'hFFFF);
    check("movn_din_wait", datapath_in, 16'hFFFF);

    // CMP R1,R1
    run_instr(16'hA901, 1'b0);
    check("cmp_edges", edges, 5);
    check("cmp_loads", n_loads, 1);
    check("cmp_loadc", n_loadc, 0);
    check("cmp_write", n_write, 0);
    check("cmp_op", al_op, 3'b001);
    check("cmp_z", {63'd0, z_flag}, 64'd1);
    check("cmp_r1", rf[1], 16'd2);

    // Illegal encodings: all-zero word and 110/11
    run_instr(16'h0000, 1'b0);
    check("ill0_edges", edges, 2);
    check("ill0_flag", n_ill, 1);
    check("ill0_strobes", n_write + n_loada + n_loadb + n_loadc + n_loads, 0);
    run_instr(16'hD8A0, 1'b0);
    check("ill1_edges", edges, 2);
    check("ill1_flag", n_ill, 1);
    check("ill1_r5", rf[5], 16'd0);

    // s held high: MOV R4,R1,LSL1 then MVN R5,R0 back-to-back
    run_instr(16'hC089, 1'b1);
    check("movr_edges", edges, 5);
    check("movr_asel", {al_asel, al_shift, al_op}, {1'b1, 3'b001, 3'b000});
    check("movr_loada", n_loada, 0);
    check("movr_r4", rf[4], 16'd4);
    run_instr(16'hB8A0, 1'b1);
    check("mvn_edges", edges, 5);
    check("mvn_op", al_op, 3'b011);
    check("mvn_r5", rf[5], 16'hFFF8);
    s = 1'b0;
    tick();

    // Reset in the middle of ADD R6,R1,R0,LSL#1
    instr = 16'hA1C8;
    s     = 1'b1;
    tick();
    s = 1'b0;
    tick();
    tick();
    check("mid_loadb", {63'd0, loadb}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_w", {63'd0, w}, 64'd1);
    check("mid_rst_outs", all_but_w(), 64'd0);
    tick();
    reset_n = 1'b1;
    n_write = 0;
    for (int i = 0; i < 6; i++) begin
      if (write || !w) n_write++;
      tick();
    end
    check("mid_no_write", n_write, 0);
    check("mid_r6", rf[6], 16'd0);
    check("mid_w", {63'd0, w}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
